// File: rtl/seq_pkg.sv
// Shared types and defaults for the stage sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STAGE   = 2'd1,
    S_DISPLAY = 2'd2,
    S_ERROR   = 2'd3
  } seq_state_e;

  localparam int unsigned DISP_DONE_CODE_DEF = 4;

  // Stage index width; kept at least 1 bit so NUM_STAGES=1 still has a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and the datapath blocks it drives.
interface stage_sequencer_if
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 6,
  parameter int unsigned DISP_W      = 3,
  parameter int unsigned FRAME_CNT_W = 8,
  parameter int unsigned TIMEOUT_W   = 16
);
  localparam int unsigned IDX_W = idx_width(NUM_STAGES);

  logic                   run;
  logic                   abort;
  logic                   loop_en;
  logic [NUM_STAGES-1:0]  stage_done;
  logic [DISP_W-1:0]      display_code;
  logic [TIMEOUT_W-1:0]   timeout_limit;
  logic                   err_clear;

  logic                   state_idle;
  logic [NUM_STAGES-1:0]  stage_active;
  logic [NUM_STAGES-1:0]  stage_start;
  logic [IDX_W-1:0]       stage_idx;
  logic                   state_display;
  logic                   state_error;
  logic                   frame_done;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic [IDX_W-1:0]       err_stage;

  modport master (
    output run, abort, loop_en, stage_done, display_code, timeout_limit, err_clear,
    input  state_idle, stage_active, stage_start, stage_idx, state_display,
           state_error, frame_done, frame_count, err_stage
  );

  modport slave (
    input  run, abort, loop_en, stage_done, display_code, timeout_limit, err_clear,
    output state_idle, stage_active, stage_start, stage_idx, state_display,
           state_error, frame_done, frame_count, err_stage
  );

endinterface

// File: rtl/seq_watchdog.sv
// Per-stage cycle counter; flags expiry on the last allowed cycle without done.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active_i,
  input  logic [TIMEOUT_W-1:0] limit_i,
  output logic                 expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  // Any cycle that is not "in a stage, still waiting" zeroes the count, so every stage entry starts at 0.
  always_comb begin
    cnt_d = '0;
    if (active_i) cnt_d = cnt_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = active_i && (limit_i != '0) && (cnt_q == limit_i - TIMEOUT_W'(1));

endmodule

// File: rtl/stage_sequencer.sv
// Frame sequencer: IDLE -> NUM_STAGES work stages -> DISPLAY, with abort, loop mode and
// frame counting. Optional per-stage watchdog/ERROR state under `SEQ_WATCHDOG_EN.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 6,
  parameter int unsigned DISP_W         = 3,
  parameter int unsigned DISP_DONE_CODE = DISP_DONE_CODE_DEF,
  parameter int unsigned FRAME_CNT_W    = 8,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input logic         clk,
  input logic         reset,
  stage_sequencer_if.slave bus
);

  localparam int unsigned      IDX_W    = idx_width(NUM_STAGES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic [IDX_W-1:0]       err_stage_q, err_stage_d;
  logic [NUM_STAGES-1:0]  stage_start_q, stage_start_d;
  logic [NUM_STAGES-1:0]  stage_active_q, stage_active_d;
  logic [IDX_W-1:0]       stage_idx_q;
  logic                   frame_done_q, frame_done_d;
  logic                   state_idle_q, state_display_q, state_error_q;

  logic done_sel;
  logic wdog_expired;

  assign done_sel = bus.stage_done[idx_q];

`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .active_i  ((state_q == S_STAGE) && !done_sel),
    .limit_i   (bus.timeout_limit),
    .expired_o (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    err_stage_d   = err_stage_q;
    frame_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run && !bus.abort) begin
          state_d = S_STAGE;
          idx_d   = '0;
        end
      end
      S_STAGE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (done_sel) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DISPLAY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (wdog_expired) begin
          state_d     = S_ERROR;
          err_stage_d = idx_q;
          idx_d       = '0;
        end
      end
      S_DISPLAY: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.display_code == DISP_W'(DISP_DONE_CODE)) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + FRAME_CNT_W'(1);
          state_d       = (bus.loop_en && bus.run) ? S_STAGE : S_IDLE;
        end
        idx_d = '0;
      end
      S_ERROR: begin
        if (bus.err_clear) begin
          state_d     = S_IDLE;
          err_stage_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // A stage is "entered" when we arrive from outside STAGE or the index moves.
  always_comb begin
    stage_start_d  = '0;
    stage_active_d = '0;
    if (state_d == S_STAGE) begin
      stage_active_d[idx_d] = 1'b1;
      if ((state_q != S_STAGE) || (idx_d != idx_q)) stage_start_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      frame_count_q   <= '0;
      err_stage_q     <= '0;
      stage_start_q   <= '0;
      stage_active_q  <= '0;
      stage_idx_q     <= '0;
      frame_done_q    <= 1'b0;
      state_idle_q    <= 1'b1;
      state_display_q <= 1'b0;
      state_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      frame_count_q   <= frame_count_d;
      err_stage_q     <= err_stage_d;
      stage_start_q   <= stage_start_d;
      stage_active_q  <= stage_active_d;
      stage_idx_q     <= (state_d == S_STAGE) ? idx_d : '0;
      frame_done_q    <= frame_done_d;
      state_idle_q    <= (state_d == S_IDLE);
      state_display_q <= (state_d == S_DISPLAY);
      state_error_q   <= (state_d == S_ERROR);
    end
  end

  assign bus.state_idle    = state_idle_q;
  assign bus.stage_active  = stage_active_q;
  assign bus.stage_start   = stage_start_q;
  assign bus.stage_idx     = stage_idx_q;
  assign bus.state_display = state_display_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_count   = frame_count_q;

`ifdef SEQ_WATCHDOG_EN
  assign bus.state_error = state_error_q;
  assign bus.err_stage   = err_stage_q;
`else
  logic unused_wdog;
  assign unused_wdog     = ^{bus.timeout_limit, err_stage_q, state_error_q};
  assign bus.state_error = 1'b0;
  assign bus.err_stage   = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (NUM_STAGES=6, done code 4).
module tb_stage_sequencer;

  localparam int unsigned NS = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  stage_sequencer_if #(
    .NUM_STAGES  (NS),
    .DISP_W      (3),
    .FRAME_CNT_W (8),
    .TIMEOUT_W   (16)
  ) bus ();

  stage_sequencer #(
    .NUM_STAGES     (NS),
    .DISP_W         (3),
    .DISP_DONE_CODE (4),
    .FRAME_CNT_W    (8),
    .TIMEOUT_W      (16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, ".idle"},    32'(bus.state_idle), 32'd1);
    check_eq({tag, ".active"},  32'(bus.stage_active), 32'd0);
    check_eq({tag, ".start"},   32'(bus.stage_start), 32'd0);
    check_eq({tag, ".idx"},     32'(bus.stage_idx), 32'd0);
    check_eq({tag, ".disp"},    32'(bus.state_display), 32'd0);
    check_eq({tag, ".err"},     32'(bus.state_error), 32'd0);
    check_eq({tag, ".fdone"},   32'(bus.frame_done), 32'd0);
    check_eq({tag, ".fcount"},  32'(bus.frame_count), 32'd0);
    check_eq({tag, ".errstg"},  32'(bus.err_stage), 32'd0);
  endtask

  // From IDLE with run=1: enter stage 0, then complete stages 0..n-1 one cycle each.
  task automatic go_to_stage(input int unsigned n);
    bus.run = 1'b1;
    step();
    for (int unsigned i = 0; i < n; i++) begin
      bus.stage_done = NS'(1) << i;
      step();
      bus.stage_done = '0;
    end
  endtask

  initial begin
    bus.run = 1'b0;
    bus.abort = 1'b0;
    bus.loop_en = 1'b0;
    bus.stage_done = '0;
    bus.display_code = '0;
    bus.timeout_limit = '0;
    bus.err_clear = 1'b0;

    step();
    step();
    check_reset_outs("rst");
    reset = 1'b0;

    // 1: full frame, each done 3 cycles after its stage start
    bus.run = 1'b1;
    step();
    for (int unsigned i = 0; i < NS; i++) begin
      check_eq($sformatf("t1.start%0d", i),  32'(bus.stage_start), 32'(NS'(1) << i));
      check_eq($sformatf("t1.active%0d", i), 32'(bus.stage_active), 32'(NS'(1) << i));
      check_eq($sformatf("t1.idx%0d", i),    32'(bus.stage_idx), i);
      step();
      check_eq($sformatf("t1.nostart%0d", i), 32'(bus.stage_start), 32'd0);
      step();
      step();
      bus.stage_done = NS'(1) << i;
      step();
      bus.stage_done = '0;
    end
    check_eq("t1.disp",   32'(bus.state_display), 32'd1);
    check_eq("t1.dact",   32'(bus.stage_active), 32'd0);
    bus.run = 1'b0;
    bus.display_code = 3'd4;
    step();
    check_eq("t1.fdone",  32'(bus.frame_done), 32'd1);
    check_eq("t1.fcount", 32'(bus.frame_count), 32'd1);
    check_eq("t1.idle",   32'(bus.state_idle), 32'd1);
    bus.display_code = '0;
    step();
    check_eq("t1.fdone_pulse", 32'(bus.frame_done), 32'd0);

    // 2: all done bits held -> one cycle per stage
    bus.stage_done = '1;
    bus.run = 1'b1;
    for (int unsigned i = 0; i < NS; i++) step();
    check_eq("t2.idx5",  32'(bus.stage_idx), 32'd5);
    check_eq("t2.nodisp", 32'(bus.state_display), 32'd0);
    step();
    check_eq("t2.disp",  32'(bus.state_display), 32'd1);
    bus.stage_done = '0;
    bus.run = 1'b0;
    bus.abort = 1'b1;
    step();
    check_eq("t2.abort_idle",   32'(bus.state_idle), 32'd1);
    check_eq("t2.abort_fdone",  32'(bus.frame_done), 32'd0);
    check_eq("t2.abort_fcount", 32'(bus.frame_count), 32'd1);
    bus.abort = 1'b0;

    // 3: other done bits ignored; abort beats done at stage 3
    go_to_stage(3);
    check_eq("t3.idx3", 32'(bus.stage_idx), 32'd3);
    bus.stage_done = 6'b110111;
    step();
    check_eq("t3.ignore", 32'(bus.stage_idx), 32'd3);
    bus.stage_done = 6'b001000;
    bus.abort = 1'b1;
    step();
    check_eq("t3.idle",   32'(bus.state_idle), 32'd1);
    check_eq("t3.active", 32'(bus.stage_active), 32'd0);
    check_eq("t3.fcount", 32'(bus.frame_count), 32'd1);
    bus.stage_done = '0;
    bus.abort = 1'b0;
    bus.run = 1'b0;
    step();
    check_eq("t3.abort_idle_noeffect", 32'(bus.state_idle), 32'd1);

    // 4: loop mode, three frames from a fresh count
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.loop_en = 1'b1;
    bus.stage_done = '1;
    bus.run = 1'b1;
    step();
    for (int unsigned f = 1; f <= 3; f++) begin
      for (int unsigned i = 0; i < NS; i++) step();
      check_eq($sformatf("t4.disp%0d", f), 32'(bus.state_display), 32'd1);
      if (f == 3) bus.run = 1'b0;
      bus.display_code = 3'd4;
      step();
      bus.display_code = '0;
      check_eq($sformatf("t4.fdone%0d", f),  32'(bus.frame_done), 32'd1);
      check_eq($sformatf("t4.fcount%0d", f), 32'(bus.frame_count), f);
      if (f < 3) begin
        check_eq($sformatf("t4.restart%0d", f), 32'(bus.stage_start), 32'd1);
        check_eq($sformatf("t4.ridx%0d", f),    32'(bus.stage_idx), 32'd0);
      end else begin
        check_eq("t4.idle", 32'(bus.state_idle), 32'd1);
      end
    end
    bus.loop_en = 1'b0;
    bus.stage_done = '0;

    // 5: watchdog on stage 2
    bus.timeout_limit = 16'd10;
    go_to_stage(2);
    for (int unsigned c = 0; c < 9; c++) step();
`ifdef SEQ_WATCHDOG_EN
    check_eq("t5.pre_idx",  32'(bus.stage_idx), 32'd2);
    check_eq("t5.pre_err",  32'(bus.state_error), 32'd0);
    step();
    check_eq("t5.err",      32'(bus.state_error), 32'd1);
    check_eq("t5.errstg",   32'(bus.err_stage), 32'd2);
    check_eq("t5.err_act",  32'(bus.stage_active), 32'd0);
    bus.abort = 1'b1;
    step();
    check_eq("t5.err_hold", 32'(bus.state_error), 32'd1);
    bus.abort = 1'b0;
    bus.run = 1'b0;
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    check_eq("t5.clr_idle",   32'(bus.state_idle), 32'd1);
    check_eq("t5.clr_errstg", 32'(bus.err_stage), 32'd0);
    bus.timeout_limit = '0;
    go_to_stage(2);
    for (int unsigned c = 0; c < 40; c++) step();
    check_eq("t5.nolimit_idx", 32'(bus.stage_idx), 32'd2);
    check_eq("t5.nolimit_err", 32'(bus.state_error), 32'd0);
`else
    for (int unsigned c = 0; c < 20; c++) step();
    check_eq("t5.nowd_idx", 32'(bus.stage_idx), 32'd2);
    check_eq("t5.nowd_err", 32'(bus.state_error), 32'd0);
    check_eq("t5.nowd_stg", 32'(bus.err_stage), 32'd0);
`endif
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.run = 1'b0;
    check_eq("t5.abort_idle", 32'(bus.state_idle), 32'd1);

    // 6: reset mid-stage 4
    go_to_stage(4);
    check_eq("t6.idx4",   32'(bus.stage_idx), 32'd4);
    check_eq("t6.fcount", 32'(bus.frame_count), 32'd3);
    reset = 1'b1;
    step();
    check_reset_outs("t6");
    reset = 1'b0;
    bus.run = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
